// File: rtl/can_pkg.sv
// rtl/can_pkg.sv - shared constants and state type for the CAN CRC-15 sequencer
package can_pkg;

  localparam int CAN_CRC_W = 15;
  localparam logic [CAN_CRC_W-1:0] CAN_CRC_POLY = 15'h4599;

  localparam int ID_W      = 11;
  localparam int DLC_W     = 4;
  localparam int CTRL_BITS = 6;
  localparam int DATA_W    = 64;
  localparam int CNT_W     = 7;

  // Frame bit indices (SOF is bit 0) of the last bit of each header field
  localparam int ARB_LAST  = ID_W + 1;              // id[10:0] then rtr
  localparam int CTRL_LAST = ARB_LAST + CTRL_BITS;  // IDE, r0, dlc[3:0]

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SOF,
    ST_ARB,
    ST_CTRL,
    ST_DATA,
    ST_FINISH
  } crc_seq_state_t;

endpackage

// File: rtl/crc15_step.sv
// rtl/crc15_step.sv - combinational one-bit CAN CRC-15 update
module crc15_step
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] POLY = CAN_CRC_POLY
) (
  input  logic                 bit_in,
  input  logic [CAN_CRC_W-1:0] crc_in,
  output logic [CAN_CRC_W-1:0] crc_out
);

  logic fb;

  // Feedback is the incoming bit against the register MSB; poly folds in when set
  always_comb begin
    fb      = bit_in ^ crc_in[CAN_CRC_W-1];
    crc_out = {crc_in[CAN_CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  end

endmodule

// File: rtl/can_crc_sequencer.sv
// rtl/can_crc_sequencer.sv - CAN frame serializer driving a bit-serial CRC-15
module can_crc_sequencer
  import can_pkg::*;
#(
  parameter logic [CAN_CRC_W-1:0] CRC_POLY  = CAN_CRC_POLY,
  parameter logic [CAN_CRC_W-1:0] CRC_INIT  = 15'h0000,
  parameter int                   MAX_BYTES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_en,
  input  logic                 start,
  input  logic                 abort,
  input  logic [ID_W-1:0]      id,
  input  logic                 rtr,
  input  logic [DLC_W-1:0]     dlc,
  input  logic [DATA_W-1:0]    data,
  input  logic                 check_en,
  input  logic [CAN_CRC_W-1:0] rx_crc,
  output logic                 busy,
  output logic                 bit_out,
  output logic                 bit_valid,
  output logic                 done,
  output logic [CAN_CRC_W-1:0] checksum,
  output logic                 crc_ok
);

  localparam logic [DLC_W-1:0] MAXB     = DLC_W'(MAX_BYTES);
  localparam logic [CNT_W-1:0] SOF_END  = '0;
  localparam logic [CNT_W-1:0] ARB_END  = CNT_W'(ARB_LAST);
  localparam logic [CNT_W-1:0] CTRL_END = CNT_W'(CTRL_LAST);
  // Offset so that (DATA_TOP - cnt) walks data from bit 63 down as cnt climbs past CTRL_END
  localparam logic [CNT_W-1:0] DATA_TOP = CNT_W'(CTRL_LAST + DATA_W);

  crc_seq_state_t          state;
  logic [CNT_W-1:0]        cnt;
  logic [CNT_W-1:0]        last_q;
  logic [ID_W-1:0]         id_q;
  logic                    rtr_q;
  logic [DLC_W-1:0]        dlc_q;
  logic [DATA_W-1:0]       data_q;
  logic [CAN_CRC_W-1:0]    rx_crc_q;
  logic                    check_q;
  logic [CAN_CRC_W-1:0]    crc_q;
  logic [CAN_CRC_W-1:0]    crc_next;
  logic [DLC_W-1:0]        nbytes;
  logic                    in_frame;
  logic [3:0]              arb_idx;
  logic [1:0]              dlc_idx;
  logic [5:0]              data_idx;

  // Covered data bytes for the descriptor being presented on the inputs
  always_comb begin
    nbytes = '0;
    if (!rtr) begin
      nbytes = (dlc > MAXB) ? MAXB : dlc;
    end
  end

  // Select the frame bit addressed by the bit counter; recessive outside a frame
  always_comb begin
    in_frame = (state == ST_SOF) || (state == ST_ARB) ||
               (state == ST_CTRL) || (state == ST_DATA);
    arb_idx  = 4'(ARB_END - 7'd1 - cnt);
    dlc_idx  = 2'(CTRL_END - cnt);
    data_idx = 6'(DATA_TOP - cnt);
    bit_out  = 1'b1;
    case (state)
      ST_SOF:  bit_out = 1'b0;
      ST_ARB:  bit_out = (cnt == ARB_END) ? rtr_q : id_q[arb_idx];
      ST_CTRL: bit_out = (cnt <= ARB_END + 7'd2) ? 1'b0 : dlc_q[dlc_idx];
      ST_DATA: bit_out = data_q[data_idx];
      default: bit_out = 1'b1;
    endcase
    bit_valid = bit_en & in_frame;
  end

  crc15_step #(
    .POLY(CRC_POLY)
  ) u_step (
    .bit_in (bit_out),
    .crc_in (crc_q),
    .crc_out(crc_next)
  );

  // Frame sequencing: latch descriptor, step one bit per tick, publish result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      last_q   <= '0;
      id_q     <= '0;
      rtr_q    <= 1'b0;
      dlc_q    <= '0;
      data_q   <= '0;
      rx_crc_q <= '0;
      check_q  <= 1'b0;
      crc_q    <= CRC_INIT;
      busy     <= 1'b0;
      done     <= 1'b0;
      checksum <= CRC_INIT;
      crc_ok   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // Cancel wins over everything, including a simultaneous start
        state <= ST_IDLE;
        busy  <= 1'b0;
        cnt   <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start) begin
              id_q     <= id;
              rtr_q    <= rtr;
              dlc_q    <= dlc;
              data_q   <= data;
              rx_crc_q <= rx_crc;
              check_q  <= check_en;
              last_q   <= CTRL_END + {nbytes, 3'b000};
              crc_q    <= CRC_INIT;
              cnt      <= '0;
              busy     <= 1'b1;
              state    <= ST_SOF;
            end
          end
          ST_SOF, ST_ARB, ST_CTRL, ST_DATA: begin
            if (bit_en) begin
              crc_q <= crc_next;
              cnt   <= cnt + 7'd1;
              if (cnt == last_q) begin
                state    <= ST_FINISH;
                done     <= 1'b1;
                checksum <= crc_next;
                crc_ok   <= check_q && (crc_next == rx_crc_q);
              end else begin
                case (state)
                  ST_SOF:  if (cnt == SOF_END)  state <= ST_ARB;
                  ST_ARB:  if (cnt == ARB_END)  state <= ST_CTRL;
                  ST_CTRL: if (cnt == CTRL_END) state <= ST_DATA;
                  default: ;
                endcase
              end
            end
          end
          ST_FINISH: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end
          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_can_crc_sequencer.sv
// tb/tb_can_crc_sequencer.sv - randomized self-checking bench for can_crc_sequencer
module tb_can_crc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bit_en = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [10:0] id = '0;
  logic        rtr = 1'b0;
  logic [3:0]  dlc = '0;
  logic [63:0] data = '0;
  logic        check_en = 1'b0;
  logic [14:0] rx_crc = '0;
  logic        busy, bit_out, bit_valid, done, crc_ok;
  logic [14:0] checksum;

  int vectors = 0;
  int miscompares = 0;

  // results of the most recent run_frame
  int          r_ticks, r_nbad, r_gap;
  bit          r_done, r_busy_start, r_busy_after, r_done_after, r_idle_bit, r_timeout;
  logic [14:0] r_cks;
  logic        r_ok;

  can_crc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .bit_en(bit_en), .start(start), .abort(abort),
    .id(id), .rtr(rtr), .dlc(dlc), .data(data), .check_en(check_en), .rx_crc(rx_crc),
    .busy(busy), .bit_out(bit_out), .bit_valid(bit_valid), .done(done),
    .checksum(checksum), .crc_ok(crc_ok)
  );

  always #5 clk = ~clk;

  function automatic int nbytes(input bit frtr, input logic [3:0] fdlc);
    if (frtr) return 0;
    return (fdlc > 8) ? 8 : int'(fdlc);
  endfunction

  function automatic int frame_len(input bit frtr, input logic [3:0] fdlc);
    return 19 + 8 * nbytes(frtr, fdlc);
  endfunction

  // Whole frame laid out as one vector: SOF, id, rtr, IDE, r0, dlc, data bytes
  function automatic bit frame_bit(input logic [10:0] fid, input bit frtr, input logic [3:0] fdlc,
                                   input logic [63:0] fdata, input int i);
    logic [82:0] v;
    v = {1'b0, fid, frtr, 2'b00, fdlc, fdata};
    return v[82 - i];
  endfunction

  // CRC as the remainder of M(x)*x^15 divided by the generator polynomial
  function automatic logic [14:0] ref_crc(input logic [10:0] fid, input bit frtr,
                                          input logic [3:0] fdlc, input logic [63:0] fdata);
    logic [15:0] rem;
    int len;
    rem = '0;
    len = frame_len(frtr, fdlc);
    for (int i = 0; i < len + 15; i++) begin
      rem = {rem[14:0], (i < len) ? frame_bit(fid, frtr, fdlc, fdata, i) : 1'b0};
      if (rem[15]) rem = rem ^ 16'hC599;
    end
    return rem[14:0];
  endfunction

  task automatic run_frame(input logic [10:0] fid, input bit frtr, input logic [3:0] fdlc,
                           input logic [63:0] fdata, input bit fchk, input logic [14:0] frx,
                           input int period, input int abort_at, input int glitch_at);
    bit pend;
    bit fin;
    int last_tick;
    r_ticks = 0; r_nbad = 0; r_gap = -1; r_done = 0; r_cks = 'x; r_ok = 'x;
    r_busy_after = 1; r_done_after = 1; r_idle_bit = 0; r_timeout = 0;
    pend = 0; fin = 0; last_tick = -100;
    @(negedge clk);
    id = fid; rtr = frtr; dlc = fdlc; data = fdata; check_en = fchk; rx_crc = frx;
    start = 1; bit_en = 0;
    @(negedge clk);
    start = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (pend) begin
        abort = 1; bit_en = 0;
      end else begin
        bit_en = ((cyc % period) == 0);
      end
      start = (glitch_at >= 0 && cyc == glitch_at);
      id = start ? ~fid : fid;
      #1;
      if (cyc == 0) r_busy_start = busy;
      if (done) begin
        r_done = 1; r_gap = cyc - last_tick; r_cks = checksum; r_ok = crc_ok;
      end
      if (bit_valid) begin
        if (bit_out !== frame_bit(fid, frtr, fdlc, fdata, r_ticks)) r_nbad++;
        last_tick = cyc;
        r_ticks++;
      end
      if (pend || r_done) begin
        @(negedge clk);
        abort = 0; start = 0; id = fid;
        #1;
        r_busy_after = busy; r_done_after = done; r_idle_bit = bit_out;
        fin = 1;
        break;
      end
      if (abort_at > 0 && bit_valid && r_ticks == abort_at) pend = 1;
    end
    start = 0; abort = 0; id = fid;
    if (!fin) r_timeout = 1;
  endtask

  task automatic test_reset;
    bit_en = 1;
    #1;
    vectors++;
    if ({busy, bit_out, bit_valid, done, checksum, crc_ok} !== {1'b0, 1'b1, 1'b0, 1'b0, 15'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset: busy=%b bit_out=%b bit_valid=%b done=%b checksum=%h crc_ok=%b, want 0 1 0 0 0000 0",
               busy, bit_out, bit_valid, done, checksum, crc_ok);
    end
    bit_en = 0;
  endtask

  // Full-frame checks shared by every scenario that lets a frame complete
  task automatic check_complete(input string name, input int exp_ticks, input logic [14:0] exp_cks,
                                input logic exp_ok);
    vectors++;
    if (r_timeout || !r_done || r_ticks != exp_ticks || r_nbad != 0 || r_gap != 1) begin
      miscompares++;
      $display("FAIL %s frame: done=%b timeout=%b ticks=%0d bad_bits=%0d gap=%0d, want done=1 ticks=%0d bad_bits=0 gap=1",
               name, r_done, r_timeout, r_ticks, r_nbad, r_gap, exp_ticks);
    end
    vectors++;
    if (r_cks !== exp_cks || r_ok !== exp_ok) begin
      miscompares++;
      $display("FAIL %s result: checksum=%h crc_ok=%b, want %h %b", name, r_cks, r_ok, exp_cks, exp_ok);
    end
    vectors++;
    if (r_busy_start !== 1'b1 || r_busy_after !== 1'b0 || r_done_after !== 1'b0 || r_idle_bit !== 1'b1) begin
      miscompares++;
      $display("FAIL %s handshake: busy_start=%b busy_after=%b done_after=%b idle_bit=%b, want 1 0 0 1",
               name, r_busy_start, r_busy_after, r_done_after, r_idle_bit);
    end
  endtask

  task automatic test_zero_frame;
    run_frame(11'h0, 0, 4'h0, 64'h0, 0, 15'h0, 1, 0, -1);
    check_complete("zero", 19, 15'h0000, 1'b0);
  endtask

  task automatic test_basic;
    logic [63:0] d;
    logic [14:0] g;
    d = {16'hABCD, 48'h0};
    g = ref_crc(11'h123, 0, 4'd2, d);
    run_frame(11'h123, 0, 4'd2, d, 0, 15'h0, 1, 0, -1);
    check_complete("basic_tx", 35, g, 1'b0);
    run_frame(11'h123, 0, 4'd2, d, 1, g, 1, 0, -1);
    check_complete("basic_rx_ok", 35, g, 1'b1);
    run_frame(11'h123, 0, 4'd2, d, 1, g ^ 15'h1, 1, 0, -1);
    check_complete("basic_rx_bad", 35, g, 1'b0);
  endtask

  task automatic test_lengths;
    logic [63:0] d;
    d = {$urandom, $urandom};
    run_frame(11'h5A5, 1, 4'd8, d, 0, 15'h0, 1, 0, -1);
    check_complete("rtr", 19, ref_crc(11'h5A5, 1, 4'd8, d), 1'b0);
    run_frame(11'h7FF, 0, 4'hF, d, 0, 15'h0, 1, 0, -1);
    check_complete("clamp", 83, ref_crc(11'h7FF, 0, 4'hF, d), 1'b0);
  endtask

  task automatic test_sparse_bit_en;
    logic [63:0] d;
    logic [14:0] dense;
    d = {$urandom, $urandom};
    run_frame(11'h2C3, 0, 4'd1, d, 0, 15'h0, 1, 0, -1);
    dense = r_cks;
    check_complete("dense", 27, ref_crc(11'h2C3, 0, 4'd1, d), 1'b0);
    run_frame(11'h2C3, 0, 4'd1, d, 0, 15'h0, 4, 0, -1);
    check_complete("sparse", 27, ref_crc(11'h2C3, 0, 4'd1, d), 1'b0);
    vectors++;
    if (r_cks !== dense) begin
      miscompares++;
      $display("FAIL sparse_vs_dense: checksum=%h, want %h", r_cks, dense);
    end
  endtask

  task automatic test_abort;
    logic [63:0] d;
    logic [14:0] prev;
    d = {$urandom, $urandom};
    prev = ref_crc(11'h2C3, 0, 4'd1, d);
    run_frame(11'h2C3, 0, 4'd1, d, 0, 15'h0, 1, 0, -1);
    run_frame(11'h1F0, 0, 4'd3, d, 0, 15'h0, 1, 10, -1);
    vectors++;
    if (r_timeout || r_done || r_busy_after !== 1'b0 || r_done_after !== 1'b0 || checksum !== prev) begin
      miscompares++;
      $display("FAIL abort: done_seen=%b busy_after=%b done_after=%b checksum=%h, want 0 0 0 %h",
               r_done, r_busy_after, r_done_after, checksum, prev);
    end
    // abort and start together: nothing starts
    @(negedge clk);
    start = 1; abort = 1;
    @(negedge clk);
    start = 0; abort = 0; bit_en = 1;
    #1;
    vectors++;
    if (busy !== 1'b0 || bit_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_start: busy=%b bit_valid=%b, want 0 0", busy, bit_valid);
    end
    bit_en = 0;
    run_frame(11'h1F0, 0, 4'd3, d, 0, 15'h0, 1, 0, -1);
    check_complete("after_abort", 43, ref_crc(11'h1F0, 0, 4'd3, d), 1'b0);
    // a start pulse mid-frame with a different id must not disturb the frame
    run_frame(11'h0F1, 0, 4'd2, d, 0, 15'h0, 2, 0, 9);
    check_complete("start_busy", 35, ref_crc(11'h0F1, 0, 4'd2, d), 1'b0);
  endtask

  task automatic test_reset_mid;
    logic [63:0] d;
    d = {$urandom, $urandom};
    @(negedge clk);
    id = 11'h3AB; rtr = 0; dlc = 4'd4; data = d; check_en = 1; rx_crc = 15'h0; start = 1;
    @(negedge clk);
    start = 0; bit_en = 1;
    repeat (25) @(negedge clk);
    #2 rst_n = 0;
    #1;
    vectors++;
    if ({busy, bit_out, bit_valid, done, checksum, crc_ok} !== {1'b0, 1'b1, 1'b0, 1'b0, 15'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_mid: busy=%b bit_out=%b bit_valid=%b done=%b checksum=%h crc_ok=%b, want 0 1 0 0 0000 0",
               busy, bit_out, bit_valid, done, checksum, crc_ok);
    end
    @(negedge clk);
    rst_n = 1; bit_en = 0;
    run_frame(11'h3AB, 0, 4'd4, d, 0, 15'h0, 1, 0, -1);
    check_complete("after_reset", 51, ref_crc(11'h3AB, 0, 4'd4, d), 1'b0);
  endtask

  task automatic test_random;
    logic [10:0] fid;
    bit          frtr, fchk, good;
    logic [3:0]  fdlc;
    logic [63:0] d;
    logic [14:0] g, rx;
    for (int n = 0; n < 24; n++) begin
      fid  = 11'($urandom);
      frtr = ($urandom_range(0, 4) == 0);
      fdlc = 4'($urandom);
      d    = {$urandom, $urandom};
      fchk = 1'($urandom);
      good = 1'($urandom);
      g    = ref_crc(fid, frtr, fdlc, d);
      rx   = good ? g : (g ^ 15'(1 << $urandom_range(0, 14)));
      run_frame(fid, frtr, fdlc, d, fchk, rx, $urandom_range(1, 3), 0, -1);
      check_complete("random", frame_len(frtr, fdlc), g, fchk && good);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1;
    test_zero_frame();
    test_basic();
    test_lengths();
    test_sparse_bit_en();
    test_abort();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
